mem_ctrl: RTL and testbench

- Arbitrates and sequences the single byte-wide RAM port shared by instruction fetch (IF) and the load/store stage (MEM) of the RISC-V pipeline.
- Converts one 8/16/32-bit request into back-to-back byte accesses, little-endian, lowest address first.
- Returns one ack pulse per transaction; IF and MEM stall on their own request until that ack.
- Fixed priority: MEM over IF. Transactions are non-preemptive.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM port controller: size codes, FSM states, owner codes.
package mem_ctrl_pkg;

    localparam logic [1:0] MemSizeByte = 2'b00;
    localparam logic [1:0] MemSizeHalf = 2'b01;
    localparam logic [1:0] MemSizeWord = 2'b10;

    typedef enum logic [1:0] {
        MemCtrlIdle = 2'd0,
        MemCtrlXfer = 2'd1,
        MemCtrlAck  = 2'd2
    } mem_ctrl_state_t;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerIf   = 2'd1,
        OwnerMem  = 2'd2
    } mem_ctrl_owner_t;

    // Index of the last byte of a transfer (N-1); size 11 behaves as a word.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        case (size)
            MemSizeByte: return 2'd0;
            MemSizeHalf: return 2'd1;
            MemSizeWord: return 2'd3;
            default:     return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester (IF, MEM) handshakes plus the byte-wide RAM port; slave = controller side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [31:0]       if_data_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_ack_o;
    logic [31:0]       mem_rdata_o;

    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_ack_o, if_data_o,
        input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output mem_ack_o, mem_rdata_o,
        output ram_a_o, ram_wr_o, ram_dout_o,
        input  ram_din_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_ack_o, if_data_o,
        output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  mem_ack_o, mem_rdata_o,
        input  ram_a_o, ram_wr_o, ram_dout_o,
        output ram_din_i
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF/MEM onto one byte-wide RAM port (MEM first, non-preemptive), N byte accesses then one ack.
// Optional IF fetch abort via if_flush_i when MEMCTRL_IF_FLUSH_EN is defined.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef MEMCTRL_IF_FLUSH_EN
    input  logic if_flush_i,
`endif
    mem_ctrl_if.slave bus
);

    mem_ctrl_state_t   r_state;
    mem_ctrl_owner_t   r_owner;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;
    logic [ADDR_W-1:0] r_ram_a;
    logic              r_ram_wr;
    logic [7:0]        r_ram_dout;
    logic [31:0]       w_rd;

    // The last byte is still on ram_din_i during the ack cycle, so it bypasses the buffer.
    always_comb begin
        w_rd = r_buf;
        w_rd[{r_last, 3'b000} +: 8] = bus.ram_din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MemCtrlIdle;
            r_owner     <= OwnerNone;
            r_cnt       <= 2'd0;
            r_last      <= 2'd0;
            r_we        <= 1'b0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_ram_a     <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= 8'd0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                MemCtrlIdle: begin
                    if (bus.mem_req_i || bus.if_req_i) begin
                        r_state <= MemCtrlXfer;
                        r_cnt   <= 2'd0;
                        r_buf   <= 32'd0;
                        if (bus.mem_req_i) begin
                            r_owner    <= OwnerMem;
                            r_we       <= bus.mem_we_i;
                            r_last     <= last_byte_idx(bus.mem_size_i);
                            r_wdata    <= bus.mem_wdata_i;
                            r_ram_a    <= bus.mem_addr_i;
                            r_ram_wr   <= bus.mem_we_i;
                            r_ram_dout <= bus.mem_wdata_i[7:0];
                        end else begin
                            r_owner    <= OwnerIf;
                            r_we       <= 1'b0;
                            r_last     <= 2'd3;
                            r_wdata    <= 32'd0;
                            r_ram_a    <= bus.if_addr_i;
                            r_ram_wr   <= 1'b0;
                            r_ram_dout <= 8'd0;
                        end
                    end
                end
                MemCtrlXfer: begin
                    // ram_din_i now carries the byte whose address was presented last cycle.
                    if (r_cnt != 2'd0)
                        r_buf[{r_cnt - 2'd1, 3'b000} +: 8] <= bus.ram_din_i;
                    if (r_cnt == r_last) begin
                        r_ram_wr  <= 1'b0;
                        r_state   <= MemCtrlAck;
                        r_if_ack  <= (r_owner == OwnerIf);
                        r_mem_ack <= (r_owner == OwnerMem);
                    end else begin
                        r_cnt      <= r_cnt + 2'd1;
                        r_ram_a    <= r_ram_a + ADDR_W'(1);
                        r_ram_wr   <= r_we;
                        r_ram_dout <= r_wdata[15:8];
                        r_wdata    <= r_wdata >> 8;
                    end
`ifdef MEMCTRL_IF_FLUSH_EN
                    if (r_owner == OwnerIf && if_flush_i) begin
                        r_state  <= MemCtrlIdle;
                        r_owner  <= OwnerNone;
                        r_if_ack <= 1'b0;
                        r_ram_wr <= 1'b0;
                    end
`endif
                end
                MemCtrlAck: begin
                    r_state <= MemCtrlIdle;
                    r_owner <= OwnerNone;
                    if (r_if_ack)
                        r_if_data <= w_rd;
                    if (r_mem_ack && !r_we)
                        r_mem_rdata <= w_rd;
                end
                default: begin
                    r_state <= MemCtrlIdle;
                    r_owner <= OwnerNone;
                end
            endcase
        end
    end

    assign bus.if_ack_o    = r_if_ack;
    assign bus.mem_ack_o   = r_mem_ack;
    assign bus.if_data_o   = r_if_ack ? w_rd : r_if_data;
    assign bus.mem_rdata_o = (r_mem_ack && !r_we) ? w_rd : r_mem_rdata;
    assign bus.ram_a_o     = r_ram_a;
    assign bus.ram_wr_o    = r_ram_wr;
    assign bus.ram_dout_o  = r_ram_dout;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, transaction-level reference checked every cycle, directed literal checks.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef MEMCTRL_IF_FLUSH_EN
    logic if_flush_i = 1'b0;
`endif
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MEMCTRL_IF_FLUSH_EN
        .if_flush_i (if_flush_i),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Synchronous byte RAM: read data appears the cycle after its address.
    logic [7:0] ram [logic [31:0]];
    always @(posedge clk) begin
        bus.ram_din_i <= ram.exists(bus.ram_a_o) ? ram[bus.ram_a_o] : 8'h00;
        if (bus.ram_wr_o === 1'b1) ram[bus.ram_a_o] = bus.ram_dout_o;
    end

    logic [31:0] a_hist [0:4095];
    always @(negedge clk) begin
        if (cyc < 4096) a_hist[cyc] = bus.ram_a_o;
        if (bus.ram_wr_o === 1'b1) wr_cnt++;
    end

    // Reference: one transaction granted at cycle m_t occupies m_t+1..m_t+N+1, ack at m_t+N+1.
    logic [7:0]  gold [logic [31:0]];
    bit          m_on = 0, m_busy = 0, m_a_ok = 0, m_own_mem = 0, m_we = 0;
    int          m_t = 0, m_n = 0, m_k = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_word = 0, m_if_hold = 0, m_mem_hold = 0, m_a_last = 0;
    logic [31:0] e_a;
    bit          e_wr, e_ia, e_ma;

    always @(negedge clk) begin
        m_k = cyc - m_t - 1;
        if (m_on) begin
            e_wr = 0; e_ia = 0; e_ma = 0; e_a = m_a_last;
            if (m_busy) begin
                if (m_k < m_n) begin
                    e_a = 32'(m_addr + m_k);
                    e_wr = m_we;
                end else begin
                    e_a = 32'(m_addr + m_n - 1);
                    e_ia = !m_own_mem;
                    e_ma = m_own_mem;
                end
            end
            chk("if_ack", bus.if_ack_o, e_ia);
            chk("mem_ack", bus.mem_ack_o, e_ma);
            chk("ram_wr", bus.ram_wr_o, e_wr);
            if (m_busy || m_a_ok) chk("ram_a", bus.ram_a_o, e_a);
            if (e_wr) chk("ram_dout", bus.ram_dout_o, m_wdata[8*m_k +: 8]);
            chk("if_data", bus.if_data_o, e_ia ? m_word : m_if_hold);
            if (!(e_ma && m_we)) chk("mem_rdata", bus.mem_rdata_o, e_ma ? m_word : m_mem_hold);
        end
        if (rst) begin
            m_on = 1; m_busy = 0; m_a_ok = 1;
            m_if_hold = 0; m_mem_hold = 0; m_a_last = 0;
        end else if (m_on) begin
            if (m_busy && m_k == m_n) begin
                if (!m_own_mem) m_if_hold = m_word;
                else if (!m_we) m_mem_hold = m_word;
                m_a_last = 32'(m_addr + m_n - 1);
                m_busy = 0;
            end
`ifdef MEMCTRL_IF_FLUSH_EN
            else if (m_busy && !m_own_mem && if_flush_i) begin
                m_busy = 0;
                m_a_ok = 0;
            end
`endif
            else if (!m_busy && (bus.mem_req_i || bus.if_req_i)) begin
                m_busy = 1; m_t = cyc; m_a_ok = 1; m_word = 0;
                if (bus.mem_req_i) begin
                    m_own_mem = 1; m_we = bus.mem_we_i;
                    m_addr = bus.mem_addr_i; m_wdata = bus.mem_wdata_i;
                    m_n = (bus.mem_size_i == 2'b00) ? 1 : (bus.mem_size_i == 2'b01) ? 2 : 4;
                end else begin
                    m_own_mem = 0; m_we = 0; m_addr = bus.if_addr_i; m_wdata = 0; m_n = 4;
                end
                for (int i = 0; i < m_n; i++) begin
                    if (m_we) gold[32'(m_addr + i)] = m_wdata[8*i +: 8];
                    else m_word[8*i +: 8] = gold.exists(32'(m_addr + i)) ? gold[32'(m_addr + i)] : 8'h00;
                end
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        gold[a] = d;
    endtask

    // Raise requests in the current cycle, drop each the cycle after its ack; latencies relative to t0.
    task automatic xact(input bit do_if, input logic [31:0] ia,
                        input bit do_mem, input bit we, input logic [1:0] sz,
                        input logic [31:0] ma, input logic [31:0] wd,
                        output int il, output int ml, output int t0,
                        output logic [31:0] iw, output logic [31:0] mw);
        bit ip, mp;
        bus.if_req_i = do_if;   bus.if_addr_i = ia;
        bus.mem_req_i = do_mem; bus.mem_we_i = we; bus.mem_size_i = sz;
        bus.mem_addr_i = ma;    bus.mem_wdata_i = wd;
        t0 = cyc; ip = do_if; mp = do_mem; il = -1; ml = -1; iw = '0; mw = '0;
        for (int i = 0; i < 40 && (ip || mp); i++) begin
            @(negedge clk);
            if (ip && bus.if_ack_o) begin il = cyc - t0; iw = bus.if_data_o; ip = 0; end
            if (mp && bus.mem_ack_o) begin ml = cyc - t0; mw = bus.mem_rdata_o; mp = 0; end
            @(posedge clk); #1;
            if (!ip) bus.if_req_i = 1'b0;
            if (!mp) bus.mem_req_i = 1'b0;
            if (i == 0) begin
                // Granted fields must already be latched; disturb them.
                if (do_mem) begin
                    bus.mem_we_i = ~we; bus.mem_size_i = ~sz;
                    bus.mem_addr_i = ma ^ 32'hFFFF_0000; bus.mem_wdata_i = ~wd;
                end else begin
                    bus.if_addr_i = ~ia;
                end
            end
        end
        if (ip || mp) chk("xact_timeout", {30'd0, ip, mp}, 32'd0);
    endtask

    initial begin
        int il, ml, t0, mc;
        logic [31:0] iw, mw;
        bit saw;
        int w0;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.mem_req_i = 0; bus.mem_we_i = 0;
        bus.mem_size_i = 0; bus.mem_addr_i = 0; bus.mem_wdata_i = 0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        preload(32'h2002, 8'h55);
        preload(32'h30, 8'h80);
        preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0, 8'h33);         preload(32'h1, 8'h44);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ram_a", bus.ram_a_o, 32'h0);
        chk("reset_if_ack", bus.if_ack_o, 32'h0);
        @(posedge clk); #1;

        // IF word fetch
        xact(1, 32'h100, 0, 0, 2'b00, 0, 0, il, ml, t0, iw, mw);
        chk("if_fetch_lat", il, 5);
        chk("if_fetch_data", iw, 32'h0010_0513);
        for (int k = 1; k <= 4; k++) chk("if_fetch_addr", a_hist[t0 + k], 32'h100 + 32'(k - 1));

        // MEM half store
        w0 = wr_cnt;
        xact(0, 0, 1, 1, 2'b01, 32'h2000, 32'hDEAD_BEEF, il, ml, t0, iw, mw);
        chk("st_half_lat", ml, 3);
        chk("st_half_writes", wr_cnt - w0, 2);
        chk("st_half_b0", ram[32'h2000], 32'hEF);
        chk("st_half_b1", ram[32'h2001], 32'hBE);
        chk("st_half_b2", ram[32'h2002], 32'h55);

        // Simultaneous IF + MEM byte load
        xact(1, 32'h100, 1, 0, 2'b00, 32'h30, 32'hFFFF_FFFF, il, ml, t0, iw, mw);
        chk("arb_mem_lat", ml, 2);
        chk("arb_mem_data", mw, 32'h0000_0080);
        chk("arb_if_lat", il, 8);
        chk("arb_if_data", iw, 32'h0010_0513);

        // Word load wrapping past the top of the address space (size 11 acts as word)
        xact(0, 0, 1, 0, 2'b11, 32'hFFFF_FFFE, 0, il, ml, t0, iw, mw);
        chk("wrap_lat", ml, 5);
        chk("wrap_data", mw, 32'h4433_2211);
        chk("wrap_addr2", a_hist[t0 + 3], 32'h0);
        chk("wrap_addr3", a_hist[t0 + 4], 32'h1);

        // Read back the half store, zero-extended
        xact(0, 0, 1, 0, 2'b01, 32'h2000, 0, il, ml, t0, iw, mw);
        chk("ld_half_data", mw, 32'h0000_BEEF);

        // Word store then byte load from its top lane
        xact(0, 0, 1, 1, 2'b10, 32'h50, 32'hCAFE_F00D, il, ml, t0, iw, mw);
        chk("st_word_lat", ml, 5);
        xact(0, 0, 1, 0, 2'b00, 32'h53, 0, il, ml, t0, iw, mw);
        chk("ld_byte_data", mw, 32'h0000_00CA);

        // Reset while byte 2 of an IF fetch is on the bus
        bus.if_req_i = 1; bus.if_addr_i = 32'h100; t0 = cyc;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid_addr", bus.ram_a_o, 32'h102);
        rst = 1'b1; bus.if_req_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ram_a", bus.ram_a_o, 32'h0);
        chk("rst_mid_ram_wr", bus.ram_wr_o, 32'h0);
        chk("rst_mid_ram_dout", bus.ram_dout_o, 32'h0);
        chk("rst_mid_if_ack", bus.if_ack_o, 32'h0);
        chk("rst_mid_mem_ack", bus.mem_ack_o, 32'h0);
        chk("rst_mid_if_data", bus.if_data_o, 32'h0);
        chk("rst_mid_mem_rdata", bus.mem_rdata_o, 32'h0);
        rst = 1'b0;
        saw = 0;
        repeat (8) begin @(negedge clk); if (bus.if_ack_o) saw = 1; end
        chk("rst_no_if_ack", saw, 0);
        @(posedge clk); #1;
        xact(1, 32'h100, 0, 0, 2'b00, 0, 0, il, ml, t0, iw, mw);
        chk("rst_refetch_lat", il, 5);
        chk("rst_refetch_data", iw, 32'h0010_0513);

`ifdef MEMCTRL_IF_FLUSH_EN
        // Flush an IF fetch at byte 1 while a MEM byte load waits
        bus.if_req_i = 1; bus.if_addr_i = 32'h100; t0 = cyc;
        @(posedge clk); #1;
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_size_i = 2'b00; bus.mem_addr_i = 32'h30;
        @(posedge clk); #1;
        if_flush_i = 1'b1;
        @(posedge clk); #1;
        if_flush_i = 1'b0; bus.if_req_i = 1'b0;
        mc = -1; saw = 0; mw = '0;
        for (int i = 0; i < 10 && mc < 0; i++) begin
            @(negedge clk);
            if (bus.if_ack_o) saw = 1;
            if (bus.mem_ack_o) begin mc = cyc - t0; mw = bus.mem_rdata_o; end
        end
        @(posedge clk); #1;
        bus.mem_req_i = 1'b0;
        chk("flush_mem_lat", mc, 5);
        chk("flush_mem_data", mw, 32'h0000_0080);
        chk("flush_no_if_ack", saw, 0);
`else
        mc = 0;
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
